// File: rtl/pcie_irq_arbiter_pkg.sv
// Shared types and constants for the PCIe interrupt arbiter.
// States, channel limit, MSI vector width and the vector clamp helper.
package pcie_irq_pkg;

  localparam int MAX_CHAN = 8;
  localparam int VEC_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    MSI_REQ,
    LEG_ASSERT,
    LEG_WAIT,
    LEG_DEASSERT
  } irq_state_e;

  // Winner index limited to the highest vector the core allocated.
  function automatic logic [VEC_W-1:0] vec_clamp(
    input logic [VEC_W-1:0] win,
    input logic [2:0]       mm
  );
    logic [VEC_W-1:0] lim;
    lim = (8'd1 << mm) - 8'd1;
    return (win > lim) ? lim : win;
  endfunction

endpackage

// File: rtl/pcie_irq_arbiter_if.sv
// Configuration-interrupt handshake toward the PCIe endpoint core.
// master = interrupt arbiter, slave = endpoint core.
interface pcie_irq_arbiter_if;
  import pcie_irq_pkg::*;

  logic             cfg_interrupt_n;
  logic             cfg_interrupt_rdy_n;
  logic             cfg_interrupt_assert_n;
  logic [VEC_W-1:0] cfg_interrupt_di;

  modport master (
    output cfg_interrupt_n,
    output cfg_interrupt_assert_n,
    output cfg_interrupt_di,
    input  cfg_interrupt_rdy_n
  );

  modport slave (
    input  cfg_interrupt_n,
    input  cfg_interrupt_assert_n,
    input  cfg_interrupt_di,
    output cfg_interrupt_rdy_n
  );

endinterface

// File: rtl/pcie_irq_arbiter_rr_arbiter.sv
// Combinational round-robin pick over the eligible channels.
// Search begins at ptr_i and wraps from N_CHAN-1 back to 0.
module rr_arbiter #(
  parameter int N_CHAN = 4,
  parameter int CH_W   = 3
) (
  input  logic [N_CHAN-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   gnt_o,
  output logic              valid_o
);

  logic [2*N_CHAN-1:0] dbl;
  logic [N_CHAN-1:0]   rot;

  assign dbl = {req_i, req_i};
  assign rot = N_CHAN'(dbl >> ptr_i);

  // Lowest rotated offset wins; scanning downward lets it overwrite.
  always_comb begin
    int k;
    k       = 0;
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k = int'(ptr_i) + i;
        if (k >= N_CHAN) k = k - N_CHAN;
        gnt_o   = CH_W'(k);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_irq_arbiter.sv
// Multi-channel MSI / legacy INTx interrupt arbiter for the PCIe endpoint.
// Optional MSI coalescing holdoff: define IRQ_COALESCE_EN.
module pcie_irq_arbiter
  import pcie_irq_pkg::*;
#(
  parameter int N_CHAN  = 4,
  parameter int CH_W    = 3,
  parameter int HOLDOFF = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CHAN-1:0] irq_req_i,
  input  logic [N_CHAN-1:0] irq_mask_i,
  input  logic [N_CHAN-1:0] irq_ack_i,
  input  logic              msi_enable_i,
  input  logic [2:0]        msi_mmenable_i,
  pcie_irq_arbiter_if.master cfg,
  output logic [N_CHAN-1:0] pending_o,
  output logic              busy_o
);

  if (N_CHAN < 1 || N_CHAN > MAX_CHAN || (1 << CH_W) < N_CHAN ||
      HOLDOFF < 1 || HOLDOFF > 65535) begin : g_bad_cfg
    $error("pcie_irq_arbiter: illegal parameter set");
  end

  irq_state_e        state_d, state_q;
  logic [N_CHAN-1:0] pend_d, pend_q;
  logic [CH_W-1:0]   rr_d, rr_q;
  logic [CH_W-1:0]   win_d, win_q;
  logic [N_CHAN-1:0] elig, clr;
  logic [CH_W-1:0]   arb_gnt, rr_next;
  logic              arb_valid, msi_done, hold_ok;

  assign elig    = pend_q & ~irq_mask_i;
  assign rr_next = (win_q == CH_W'(N_CHAN - 1)) ? '0 : win_q + 1'b1;
  assign msi_done = (state_q == MSI_REQ) && !cfg.cfg_interrupt_rdy_n;

  rr_arbiter #(.N_CHAN(N_CHAN), .CH_W(CH_W)) u_rr (
    .req_i   (elig),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

`ifdef IRQ_COALESCE_EN
  logic [15:0] hold_d, hold_q;

  // Holdoff reloads on every MSI completion, then counts down to zero.
  always_comb begin
    hold_d = hold_q;
    if (msi_done) hold_d = 16'(HOLDOFF);
    else if (hold_q != '0) hold_d = hold_q - 16'd1;
  end

  // Holdoff counter register.
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign hold_ok = (hold_q == '0);
`else
  assign hold_ok = 1'b1;
`endif

  // Pending bits: set beats clear; MSI clears on grant, INTx on ack.
  always_comb begin
    clr = msi_enable_i ? '0 : irq_ack_i;
    if (msi_done) clr = clr | (N_CHAN'(1) << win_q);
    pend_d = (pend_q & ~clr) | irq_req_i;
  end

  // Next state, winner latch, pointer advance and core-facing outputs.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    cfg.cfg_interrupt_n        = 1'b1;
    cfg.cfg_interrupt_assert_n = 1'b1;
    cfg.cfg_interrupt_di       = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid && hold_ok) begin
          win_d   = arb_gnt;
          state_d = msi_enable_i ? MSI_REQ : LEG_ASSERT;
        end
      end
      MSI_REQ: begin
        cfg.cfg_interrupt_n  = 1'b0;
        cfg.cfg_interrupt_di = vec_clamp(VEC_W'(win_q), msi_mmenable_i);
        if (!cfg.cfg_interrupt_rdy_n) begin
          rr_d    = rr_next;
          state_d = IDLE;
        end
      end
      LEG_ASSERT: begin
        cfg.cfg_interrupt_n        = 1'b0;
        cfg.cfg_interrupt_assert_n = 1'b0;
        if (!cfg.cfg_interrupt_rdy_n) state_d = LEG_WAIT;
      end
      LEG_WAIT: begin
        if (elig == '0) state_d = LEG_DEASSERT;
      end
      LEG_DEASSERT: begin
        cfg.cfg_interrupt_n = 1'b0;
        if (!cfg.cfg_interrupt_rdy_n) begin
          rr_d    = rr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pending, pointer and winner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      rr_q    <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
    end
  end

  assign pending_o = pend_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_pcie_irq_arbiter.sv
// Self-checking bench for pcie_irq_arbiter (MSI, round-robin, clamp,
// legacy INTx, masking, reset; holdoff when IRQ_COALESCE_EN is defined).
module tb_pcie_irq_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_req, irq_mask, irq_ack;
  logic         msi_en;
  logic [2:0]   mmen;
  logic         rdy_n;
  logic [N-1:0] pending;
  logic         busy;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pcie_irq_arbiter_if cfg_if ();
  assign cfg_if.cfg_interrupt_rdy_n = rdy_n;

  pcie_irq_arbiter #(.N_CHAN(N), .CH_W(3), .HOLDOFF(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_req_i      (irq_req),
    .irq_mask_i     (irq_mask),
    .irq_ack_i      (irq_ack),
    .msi_enable_i   (msi_en),
    .msi_mmenable_i (mmen),
    .cfg            (cfg_if.master),
    .pending_o      (pending),
    .busy_o         (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; irq_req = '0; irq_mask = '0; irq_ack = '0;
    rdy_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [N-1:0] r);
    irq_req = r;
    @(negedge clk);
    irq_req = '0;
  endtask

  // Wait for a request, score its vector, answer after lat cycles.
  task automatic serve(input int lat, input string tag);
    bit seen;
    logic [7:0] e;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cfg_if.cfg_interrupt_n === 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      $display("FAIL %s: no request within 40 cycles", tag);
    end else if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected request di=%0d", tag,
               cfg_if.cfg_interrupt_di);
    end else begin
      e = exp_q.pop_front();
      if (cfg_if.cfg_interrupt_di !== e)
        $display("FAIL %s: di=%0d expected %0d", tag,
                 cfg_if.cfg_interrupt_di, e);
      else n_pass++;
    end
    if (seen) begin
      repeat (lat) @(negedge clk);
      rdy_n = 1'b0;
      @(negedge clk);
      rdy_n = 1'b1;
      n_chk++;
      if (cfg_if.cfg_interrupt_n !== 1'b1)
        $display("FAIL %s_release: n=%b expected 1", tag,
                 cfg_if.cfg_interrupt_n);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_req = '0; irq_mask = '0; irq_ack = '0;
    msi_en = 1'b1; mmen = 3'd2; rdy_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
         cfg_if.cfg_interrupt_di, pending, busy} !== {2'b11, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset: n=%b an=%b di=%0d pend=%b busy=%b",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
               cfg_if.cfg_interrupt_di, pending, busy);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_msi_single();
    do_reset();
    msi_en = 1'b1; mmen = 3'd2;
    pulse_req(4'b0100);
    n_chk++;
    if (cfg_if.cfg_interrupt_n !== 1'b1)
      $display("FAIL msi_early: n=%b expected 1", cfg_if.cfg_interrupt_n);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_di} !== {1'b0, 8'd2})
      $display("FAIL msi_req: n=%b di=%0d expected n=0 di=2",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_di);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_chk++;
    if (cfg_if.cfg_interrupt_n !== 1'b0)
      $display("FAIL msi_hold: n=%b expected 0", cfg_if.cfg_interrupt_n);
    else n_pass++;
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, pending, busy} !== {1'b1, 4'h0, 1'b0})
      $display("FAIL msi_done: n=%b pend=%b busy=%b expected 1/0000/0",
               cfg_if.cfg_interrupt_n, pending, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    msi_en = 1'b1; mmen = 3'd2;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    pulse_req(4'b1111);
    for (int i = 0; i < 4; i++) serve(1, "rr_burst1");
    exp_q.push_back(8'd0);
    pulse_req(4'b0001);
    serve(1, "rr_single0");
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd3); exp_q.push_back(8'd0);
    pulse_req(4'b1111);
    for (int i = 0; i < 4; i++) serve(1, "rr_burst2");
    @(negedge clk);
    n_chk++;
    if ({pending, busy} !== 5'b0)
      $display("FAIL rr_drain: pend=%b busy=%b expected 0000/0",
               pending, busy);
    else n_pass++;
  endtask

  task automatic test_vector_clamp();
    do_reset();
    msi_en = 1'b1; mmen = 3'd1;
    exp_q.push_back(8'd1);
    pulse_req(4'b1000);
    serve(0, "clamp_mm1");
    mmen = 3'd0;
    exp_q.push_back(8'd0);
    pulse_req(4'b1000);
    serve(2, "clamp_mm0");
    mmen = 3'd2;
  endtask

  task automatic test_legacy();
    do_reset();
    msi_en = 1'b0;
    pulse_req(4'b0010);
    @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
         cfg_if.cfg_interrupt_di} !== {2'b00, 8'h00})
      $display("FAIL leg_assert: n=%b an=%b di=%0d expected 0/0/0",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
               cfg_if.cfg_interrupt_di);
    else n_pass++;
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, busy, pending[1]} !== 3'b111)
      $display("FAIL leg_wait: n=%b busy=%b pend1=%b expected 1/1/1",
               cfg_if.cfg_interrupt_n, busy, pending[1]);
    else n_pass++;
    irq_req = 4'b0010; irq_ack = 4'b0010;
    @(negedge clk);
    irq_req = '0; irq_ack = '0;
    @(negedge clk);
    n_chk++;
    if ({pending[1], cfg_if.cfg_interrupt_n, busy} !== 3'b111)
      $display("FAIL set_over_clear: pend1=%b n=%b busy=%b expected 1/1/1",
               pending[1], cfg_if.cfg_interrupt_n, busy);
    else n_pass++;
    irq_ack = 4'b0010;
    @(negedge clk);
    irq_ack = '0;
    @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
         pending[1]} !== 3'b010)
      $display("FAIL leg_deassert: n=%b an=%b pend1=%b expected 0/1/0",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
               pending[1]);
    else n_pass++;
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    n_chk++;
    if ({busy, cfg_if.cfg_interrupt_n} !== 2'b01)
      $display("FAIL leg_idle: busy=%b n=%b expected 0/1",
               busy, cfg_if.cfg_interrupt_n);
    else n_pass++;
  endtask

  task automatic test_legacy_mask();
    do_reset();
    msi_en = 1'b0;
    pulse_req(4'b0010);
    @(negedge clk);
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    @(negedge clk);
    irq_mask = 4'b0010;
    @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
         pending[1]} !== 3'b011)
      $display("FAIL mask_deassert: n=%b an=%b pend1=%b expected 0/1/1",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
               pending[1]);
    else n_pass++;
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, cfg_if.cfg_interrupt_n, pending[1]} !== 3'b011)
      $display("FAIL mask_idle: busy=%b n=%b pend1=%b expected 0/1/1",
               busy, cfg_if.cfg_interrupt_n, pending[1]);
    else n_pass++;
    irq_mask = '0;
    msi_en = 1'b1;
  endtask

  task automatic test_msi_mask_and_held_rdy();
    do_reset();
    msi_en = 1'b1; mmen = 3'd2;
    pulse_req(4'b0001);
    @(negedge clk);
    irq_mask = 4'b0001;
    @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_di} !== {1'b0, 8'd0})
      $display("FAIL msi_masked_hold: n=%b di=%0d expected 0/0",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_di);
    else n_pass++;
    rdy_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, busy, pending} !== {2'b10, 4'h0})
      $display("FAIL held_rdy: n=%b busy=%b pend=%b expected 1/0/0000",
               cfg_if.cfg_interrupt_n, busy, pending);
    else n_pass++;
    rdy_n = 1'b1;
    irq_mask = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    msi_en = 1'b1; mmen = 3'd2;
    pulse_req(4'b0100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
         cfg_if.cfg_interrupt_di, pending, busy} !== {2'b11, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset_mid: n=%b an=%b di=%0d pend=%b busy=%b",
               cfg_if.cfg_interrupt_n, cfg_if.cfg_interrupt_assert_n,
               cfg_if.cfg_interrupt_di, pending, busy);
    else n_pass++;
    rst = 1'b0;
  endtask

`ifdef IRQ_COALESCE_EN
  task automatic test_coalesce();
    bit early;
    do_reset();
    msi_en = 1'b1; mmen = 3'd2;
    pulse_req(4'b0001);
    pulse_req(4'b0001);
    n_chk++;
    if (cfg_if.cfg_interrupt_n !== 1'b0)
      $display("FAIL coal_first: n=%b expected 0", cfg_if.cfg_interrupt_n);
    else n_pass++;
    rdy_n = 1'b0;
    @(negedge clk);
    rdy_n = 1'b1;
    irq_req = 4'b0010;
    @(negedge clk);
    irq_req = '0;
    early = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (cfg_if.cfg_interrupt_n === 1'b0) early = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (early)
      $display("FAIL coal_holdoff: request issued early, expected none");
    else n_pass++;
    exp_q.push_back(8'd1);
    serve(0, "coal_second");
    repeat (15) @(negedge clk);
    n_chk++;
    if ({pending, busy, cfg_if.cfg_interrupt_n} !== {4'h0, 2'b01})
      $display("FAIL coal_merge: pend=%b busy=%b n=%b expected 0000/0/1",
               pending, busy, cfg_if.cfg_interrupt_n);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_msi_single();
    test_round_robin();
    test_vector_clamp();
    test_legacy();
    test_legacy_mask();
    test_msi_mask_and_held_rdy();
    test_reset_mid();
`ifdef IRQ_COALESCE_EN
    test_coalesce();
`endif
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_empty: %0d left expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pcie_irq_arbiter.md
Name: pcie_irq_arbiter

Overview:
- Parametrised multi-channel interrupt controller between acquisition/DMA logic and the PCIe endpoint core configuration-interrupt port.
- Replaces the single-pulse MSI latch with:
  - per-channel pending and mask;
  - round-robin arbitration;
  - multi-message MSI vector selection;
  - a legacy INTx assert/deassert path when MSI is disabled.
- Sits in the endpoint top beside the PIO engine, clocked by the transaction clock.

Parameters:
- N_CHAN, 4, number of interrupt sources (1..8)
- CH_W, 3, width of channel index; must satisfy 2^CH_W >= N_CHAN
- HOLDOFF, 256, minimum cycles between MSI issues when the optional coalescing feature is compiled in (1..65535)

Ports:
- clk  in  1  transaction clock
- rst  in  1  synchronous reset, active-high
- irq_req_i  in  N_CHAN  per-channel request; one-cycle pulse, level also accepted
- irq_mask_i  in  N_CHAN  1 = channel masked; pending still latches
- irq_ack_i  in  N_CHAN  software clear of a pending bit (legacy mode), one-cycle pulse
- msi_enable_i  in  1  core MSI enable; 0 = legacy INTx
- msi_mmenable_i  in  3  core multi-message enable; log2 of allocated vectors
- cfg_interrupt_n  out  1  interrupt request to core, active-low
- cfg_interrupt_rdy_n  in  1  core grant, active-low
- cfg_interrupt_assert_n  out  1  legacy assert (0) / deassert (1) select
- cfg_interrupt_di  out  8  MSI vector / legacy don't-care (0)
- pending_o  out  N_CHAN  pending bits, readable by PIO registers
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - cfg_interrupt_n = 1, cfg_interrupt_assert_n = 1, cfg_interrupt_di = 0
  - pending_o = 0, busy_o = 0
  - rr pointer = 0, FSM = IDLE, holdoff counter = 0
- Pending update per channel, every cycle: pend <= (pend & ~clr) | irq_req_i.
  - clr = irq_ack_i in legacy mode; clr = grant-completion in MSI mode.
  - Set wins over a simultaneous clear.
- eligible = pending & ~irq_mask_i.
- Round-robin arbitration:
  - Search starts at the rr pointer and wraps at N_CHAN-1 → 0.
  - Winner is latched on leaving IDLE.
  - After the handshake completes, rr pointer = winner+1 (mod N_CHAN).
- Vector: cfg_interrupt_di = min(winner, 2^msi_mmenable_i − 1), zero-extended to 8 bits. msi_mmenable_i = 0 therefore gives vector 0 always.
- msi_enable_i is sampled only in IDLE; a change mid-transaction takes effect at the next IDLE.
- FSM states:
  - IDLE: if eligible ≠ 0 and holdoff counter = 0, go to MSI_REQ when msi_enable_i = 1, else go to LEG_ASSERT.
  - MSI_REQ: cfg_interrupt_n = 0, di = vector. When cfg_interrupt_rdy_n = 0, in that same cycle: cfg_interrupt_n → 1 next cycle, clear pending[winner], load holdoff, go to IDLE. Latency from request pulse to cfg_interrupt_n low is 2 cycles (pending reg + IDLE decision).
  - LEG_ASSERT: cfg_interrupt_n = 0, assert_n = 0 until rdy_n = 0 → LEG_WAIT.
  - LEG_WAIT: INTx is held asserted by the core; wait until eligible = 0 (all acked or masked) → LEG_DEASSERT.
  - LEG_DEASSERT: cfg_interrupt_n = 0, assert_n = 1 until rdy_n = 0 → IDLE.
- cfg_interrupt_n deasserts the cycle after rdy_n is seen low; a rdy_n that stays low does not re-complete.
- Masking the winner while in MSI_REQ does not abort the request; the message is still sent.
- Reset asserted mid-handshake returns all outputs to reset values on the next clock edge; in-flight pending bits are lost.

Optional Feature:
- Macro: IRQ_COALESCE_EN.
- Defined:
  - After every MSI completion, the holdoff counter loads HOLDOFF and decrements to 0.
  - IDLE does not issue a new MSI while the counter ≠ 0.
  - Requests arriving during holdoff stay pending and merge.
  - Legacy mode is unaffected.
- Undefined: counter logic absent; next MSI may issue in the cycle after returning to IDLE.

Decomposition:
- Shared package pcie_irq_pkg:
  - FSM state enum: IDLE, MSI_REQ, LEG_ASSERT, LEG_WAIT, LEG_DEASSERT
  - Constant MAX_CHAN = 8
  - Vector-width constant = 8
- One natural sub-module: rr_arbiter, combinational round-robin priority pick. Inputs: request vector, pointer. Outputs: grant index, valid.

Test Plan:
- MSI single: msi_enable = 1, mmenable = 2, pulse irq_req_i[2] → cfg_interrupt_n low 2 cycles later, di = 2; core rdy_n low 3 cycles later → cfg_interrupt_n high next cycle, pending_o = 0.
- Round-robin: pulse irq_req_i = 4'b1111 once, rdy_n answers each request after 1 cycle → vectors issued 0,1,2,3; a second burst after the pointer has advanced to 1 issues 1,2,3,0.
- Vector clamp: mmenable = 1, N_CHAN = 4, request ch3 only → di = 1; mmenable = 0 → di = 0.
- Legacy: msi_enable = 0, request ch1 → assert_n = 0 handshake, FSM holds LEG_WAIT; pulse irq_ack_i[1] → deassert handshake with assert_n = 1, FSM returns to IDLE.
- Set-over-clear and mask: in legacy LEG_WAIT, pulse irq_req_i[1] and irq_ack_i[1] together → pending_o[1] stays 1. Mask ch1 → eligible = 0 → deassert.
- Coalescing (IRQ_COALESCE_EN, HOLDOFF = 10): two requests 1 cycle apart on ch0 → one MSI. A request on ch1 during holdoff → its MSI starts no earlier than 10 cycles after the first completion. Reset asserted in MSI_REQ → cfg_interrupt_n = 1 next cycle.
